// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer
// Runs a WIDTH-bit NAND/NOR/ADD/SUB on a shared external 4-bit ALU slice,
// one nibble per cycle, least significant nibble first. The slice carry is
// chained between cycles through a register and the nibble results are
// assembled into a WIDTH-bit response returned on a valid/ready handshake.
//
// Optional build macro:
//   ALU_SLICE_SEQ_OVF_EN - adds rsp_ovf, the signed overflow flag for
//                          ADD/SUB results (always 0 for NAND/NOR).

module alu_slice_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    input  logic             req_cin,

    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic             alu_cin,
    output logic [1:0]       alu_s_op,
    input  logic [3:0]       alu_z,
    input  logic             alu_cout,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_cout
`ifdef ALU_SLICE_SEQ_OVF_EN
    ,
    output logic             rsp_ovf
`endif
);

    // Number of nibbles per operation and the width of the nibble index.
    // A single-slice build still needs a one-bit index to stay legal.
    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_NOR  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [1:0]         op_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   result_reg;
    logic [WIDTH-1:0]   result_next;
    logic [WIDTH-1:0]   z_reg;
    logic               cout_reg;

    logic [3:0]         a_slice;
    logic [3:0]         b_slice;
    logic               last_slice;
    logic               accept;

    // A request is taken only while idle; no path from rsp_ready reaches here.
    assign accept     = (state == IDLE) && req_valid;
    assign last_slice = (idx == IDX_W'(NSLICE - 1));

    // Pick the operand nibbles addressed by the current slice index.
    always_comb begin
        a_slice = 4'h0;
        b_slice = 4'h0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
                a_slice = a_reg[4*i +: 4];
                b_slice = b_reg[4*i +: 4];
            end
        end
    end

    // Merge this cycle's ALU nibble into the partially assembled result.
    always_comb begin
        result_next = result_reg;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
                result_next[4*i +: 4] = alu_z;
            end
        end
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake/ALU drive; ALU inputs idle at zero.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        alu_a      = 4'h0;
        alu_b      = 4'h0;
        alu_cin    = 1'b0;
        alu_s_op   = 2'b00;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                alu_a    = a_slice;
                alu_b    = b_slice;
                alu_cin  = carry_reg;
                alu_s_op = op_reg;
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, nibble stepping and carry chaining. The carry register
    // follows alu_cout for every op; logic ops simply return a zero carry.
    // The final nibble also loads the response registers, which then hold
    // their value until the next operation completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= 2'b00;
            carry_reg  <= 1'b0;
            idx        <= '0;
            result_reg <= '0;
            z_reg      <= '0;
            cout_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= req_a;
                        b_reg     <= req_b;
                        op_reg    <= req_op;
                        carry_reg <= req_cin;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    result_reg <= result_next;
                    carry_reg  <= alu_cout;
                    if (last_slice) begin
                        z_reg    <= result_next;
                        cout_reg <= alu_cout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_z    = z_reg;
    assign rsp_cout = cout_reg;

`ifdef ALU_SLICE_SEQ_OVF_EN
    logic ovf_reg;
    logic ovf_next;

    // Signed overflow from the operand sign bits and the final result sign.
    // SUB compares against B as written, since the ALU inverts B itself.
    always_comb begin
        ovf_next = 1'b0;
        case (op_reg)
            OP_ADD:  ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                (result_next[WIDTH-1] != a_reg[WIDTH-1]);
            OP_SUB:  ovf_next = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                                (result_next[WIDTH-1] != a_reg[WIDTH-1]);
            OP_NAND: ovf_next = 1'b0;
            OP_NOR:  ovf_next = 1'b0;
            default: ovf_next = 1'b0;
        endcase
    end

    // Capture the overflow flag alongside the last result nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state == RUN && last_slice) begin
            ovf_reg <= ovf_next;
        end
    end

    assign rsp_ovf = (state == DONE) && ovf_reg;
`endif

endmodule

// File: doc/alu_slice_sequencer.md
Name: alu_slice_sequencer

Overview:
Multi-cycle initiator that drives an external combinational 4-bit ALU slice to perform WIDTH-bit operations one nibble per cycle. It accepts a wide request on a valid/ready handshake and presents 4-bit operand slices LSB-first. Between slices it chains the ALU carry through a register, then assembles the result and returns it on a valid/ready response handshake. It sits between the datapath controller and a single shared alu_4bit instance.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4; NSLICE = WIDTH/4

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
req_op  input  2  00 NAND, 01 NOR, 10 ADD, 11 SUB
req_cin  input  1  carry-in to slice 0; SUB requires 1 for two's-complement subtract
alu_a  output  4  current A slice to ALU
alu_b  output  4  current B slice to ALU
alu_cin  output  1  carry to ALU, from carry register
alu_s_op  output  2  op select to ALU, latched req_op
alu_z  input  4  ALU slice result, combinational from alu_* in same cycle
alu_cout  input  1  ALU slice carry-out; 0 for logic ops
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_z  output  WIDTH  assembled result
rsp_cout  output  1  carry-out of final slice; 0 for NAND/NOR

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low. While rst_n is low: state IDLE, req_ready=1, rsp_valid=0, rsp_z=0, rsp_cout=0, alu_a=0, alu_b=0, alu_cin=0, alu_s_op=00, slice index=0, carry register=0.
- FSM states are IDLE, RUN and DONE.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - latch req_a, req_b, req_op;
  - carry register <= req_cin; index <= 0;
  - go to RUN.
  - alu_* outputs are driven to 0/00 in IDLE.
- RUN: req_ready=0.
  - alu_a = A[4*idx+3:4*idx]; alu_b = B[4*idx+3:4*idx]; alu_cin = carry register; alu_s_op = latched op.
  - At each edge: result[4*idx+3:4*idx] <= alu_z; carry register <= alu_cout; idx <= idx+1.
  - When idx == NSLICE-1, go to DONE instead of incrementing.
- Carry handling: for op 00/01, the carry register is still loaded from alu_cout, which is 0. For op 11, the ALU computes a + ~b + cin per slice; the sequencer does not invert operands.
- DONE: rsp_valid=1, rsp_z = assembled result, rsp_cout = carry register. Both are stable while rsp_ready=0. On rsp_ready, go to IDLE the next cycle with rsp_valid=0. No combinational path from rsp_ready to req_ready; a new request is accepted no earlier than the cycle after response acceptance.
- Latency: request accept edge, then NSLICE RUN cycles. rsp_valid rises on the edge ending the last RUN cycle, i.e. NSLICE edges after acceptance (4 for WIDTH=16). Throughput is one operation per NSLICE+2 cycles with rsp_ready held high.
- Request inputs are ignored outside IDLE. rsp_z holds its last value after return to IDLE until the next result overwrites it.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. The partial result is discarded and all outputs take their reset values.
- WIDTH=4 degenerates to a single RUN cycle.

Optional Feature:
ALU_SLICE_SEQ_OVF_EN: when defined, adds output rsp_ovf (1 bit), valid with rsp_valid and 0 in reset/IDLE.
- ADD: rsp_ovf = (A[W-1]==B[W-1]) && (Z[W-1]!=A[W-1]).
- SUB: rsp_ovf = (A[W-1]!=B[W-1]) && (Z[W-1]!=A[W-1]).
- NAND/NOR: rsp_ovf = 0.
- When undefined, the port and its logic are absent.

Test Plan:
- WIDTH=16, ADD a=0x1234 b=0x0FCD cin=0 -> rsp_z=0x2201, rsp_cout=0, rsp_valid exactly 4 edges after accept, alu_a sequence 4,3,2,1.
- ADD a=0xFFFF b=0x0001 cin=0 -> rsp_z=0x0000, rsp_cout=1, alu_cin sequence 0,1,1,1.
- SUB a=0x0005 b=0x0007 cin=1 -> rsp_z=0xFFFE, rsp_cout=0. SUB a=0x0007 b=0x0005 cin=1 -> rsp_z=0x0002, rsp_cout=1.
- NAND 0xF0F0,0xFF00 -> 0x0FFF, cout 0. NOR 0xF0F0,0x0F00 -> 0x000F, cout 0.
- rsp_ready low 3 cycles in DONE -> rsp_valid and rsp_z held, req_ready=0, concurrent req_valid ignored; after accept, the next request completes correctly.
- rst_n low after 2 RUN cycles -> all outputs at reset values asynchronously; a following ADD 0x0001+0x0001 returns 0x0002. With ALU_SLICE_SEQ_OVF_EN, ADD 0x7FFF+0x0001 -> rsp_ovf=1.
